// File: rtl/bus_cdc_arb_pkg.sv
// Shared types and helpers for the bus CDC arbiter and its round-robin picker.
package bus_cdc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // Requester tag width; never narrower than one bit.
    function automatic int calc_id_w(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/bus_cdc_arbiter_rr_select.sv
// Combinational round-robin picker: first set req bit at or after ptr, with wrap-around.
module rr_select
    import bus_cdc_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = calc_id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             valid,
    output logic [ID_W-1:0]  id
);

    logic [ID_W:0] idx;

    // Scan from the farthest candidate back towards ptr so the nearest set bit wins.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (ID_W + 1)'(k);
            if (idx >= (ID_W + 1)'(N_REQ)) begin
                idx = idx - (ID_W + 1)'(N_REQ);
            end
            if (req[idx[ID_W-1:0]]) begin
                valid = 1'b1;
                id    = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_cdc_arbiter.sv
// Round-robin arbiter sharing one four-phase CDC handshake channel between N_REQ sources.
// Optional watchdog: define BUS_CDC_ARB_TIMEOUT_EN to abort stuck handshakes after TIMEOUT cycles.
//
// state | meaning
// IDLE  | wait for a request with cdc_ack low; grant, latch {id, payload}, advance ptr
// SEND  | cdc_trigger high, wait for cdc_ack to rise
// DRAIN | cdc_trigger low, wait for cdc_ack to fall, then pulse req_ack[grant_id]
module bus_cdc_arbiter
    import bus_cdc_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = calc_id_w(N_REQ),
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data_in,
    output logic [N_REQ-1:0]       req_ack,
    output logic                   cdc_trigger,
    output logic [ID_W+WIDTH-1:0]  cdc_data,
    input  logic                   cdc_ack,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic                   timeout_err
);

    if (N_REQ < 2 || TIMEOUT < 1) begin : g_param_check
        $error("bus_cdc_arbiter: N_REQ must be >= 2 and TIMEOUT >= 1");
    end

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       grant_id_q, grant_id_d;
    logic [ID_W+WIDTH-1:0] cdc_data_q, cdc_data_d;
    logic [N_REQ-1:0]      req_ack_q, req_ack_d;
    logic                  cdc_trigger_q, cdc_trigger_d;
    logic                  busy_q, busy_d;

    logic                  sel_valid;
    logic [ID_W-1:0]       sel_id;
    logic [WIDTH-1:0]      sel_data;

`ifdef BUS_CDC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                  timeout_err_q, timeout_err_d;
`endif

    rr_select #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_select (
        .req   (req),
        .ptr   (ptr_q),
        .valid (sel_valid),
        .id    (sel_id)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_id == ID_W'(i)) begin
                sel_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        cdc_data_d    = cdc_data_q;
        req_ack_d     = '0;
        cdc_trigger_d = cdc_trigger_q;
`ifdef BUS_CDC_ARB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        unique case (state_q)
            IDLE: begin
                cdc_trigger_d = 1'b0;
                // A high ack here is left over from an aborted handshake; wait it out.
                if (sel_valid && !cdc_ack) begin
                    grant_id_d = sel_id;
                    cdc_data_d = {sel_id, sel_data};
                    ptr_d      = (sel_id == ID_W'(N_REQ - 1)) ? '0 : sel_id + ID_W'(1);
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (cdc_ack) begin
                    cdc_trigger_d = 1'b0;
                    state_d       = DRAIN;
                end else begin
                    cdc_trigger_d = 1'b1;
                end
            end
            DRAIN: begin
                cdc_trigger_d = 1'b0;
                if (!cdc_ack) begin
                    req_ack_d = N_REQ'(1) << grant_id_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                cdc_trigger_d = 1'b0;
                state_d       = IDLE;
            end
        endcase

`ifdef BUS_CDC_ARB_TIMEOUT_EN
        // Down-counter reloaded on every SEND/DRAIN entry; terminal count aborts the transfer.
        if (state_q != IDLE) begin
            if (tmo_cnt_q == '0) begin
                state_d       = IDLE;
                cdc_trigger_d = 1'b0;
                req_ack_d     = '0;
                timeout_err_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q - CNT_W'(1);
            end
        end
        if (state_d != state_q && state_d != IDLE) begin
            tmo_cnt_d = CNT_W'(TIMEOUT - 1);
        end
`endif

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            cdc_data_q    <= '0;
            req_ack_q     <= '0;
            cdc_trigger_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef BUS_CDC_ARB_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            cdc_data_q    <= cdc_data_d;
            req_ack_q     <= req_ack_d;
            cdc_trigger_q <= cdc_trigger_d;
            busy_q        <= busy_d;
`ifdef BUS_CDC_ARB_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign req_ack     = req_ack_q;
    assign cdc_trigger = cdc_trigger_q;
    assign cdc_data    = cdc_data_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;

`ifdef BUS_CDC_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cdc_arbiter.sv
// Directed bench for bus_cdc_arbiter with a behavioural four-phase ack responder.
module tb_bus_cdc_arbiter;

    localparam int N_REQ   = 4;
    localparam int WIDTH   = 32;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 15;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ*WIDTH-1:0] data_in = '0;
    logic [N_REQ-1:0]       req_ack;
    logic                   cdc_trigger;
    logic [ID_W+WIDTH-1:0]  cdc_data;
    logic                   cdc_ack;
    logic                   busy;
    logic [ID_W-1:0]        grant_id;
    logic                   timeout_err;

    logic ack_auto = 1'b0;
    logic ack_manual = 1'b0;
    logic ack_model = 1'b0;
    int   ack_dly = 0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign cdc_ack = ack_auto ? ack_model : ack_manual;

    bus_cdc_arbiter #(
        .N_REQ   (N_REQ),
        .WIDTH   (WIDTH),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .data_in     (data_in),
        .req_ack     (req_ack),
        .cdc_trigger (cdc_trigger),
        .cdc_data    (cdc_data),
        .cdc_ack     (cdc_ack),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    // Ack follows trigger: rises 3 cycles after trigger goes high, falls 3 cycles after it drops.
    always @(negedge clk) begin
        if (!ack_auto) begin
            ack_model = 1'b0;
            ack_dly   = 0;
        end else if (cdc_trigger != ack_model) begin
            if (ack_dly == 3) begin
                ack_model = cdc_trigger;
                ack_dly   = 0;
            end else begin
                ack_dly++;
            end
        end else begin
            ack_dly = 0;
        end
    end

    task automatic apply_reset(input logic ack_level);
        ack_auto   = 1'b0;
        ack_manual = ack_level;
        req        = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(1'b0);
        n_cmp++; if (req_ack !== 4'b0000) begin n_err++; $display("FAIL reset_req_ack: got %b want 0000", req_ack); end
        n_cmp++; if (cdc_trigger !== 1'b0) begin n_err++; $display("FAIL reset_trigger: got %b want 0", cdc_trigger); end
        n_cmp++; if (cdc_data !== 34'h0) begin n_err++; $display("FAIL reset_cdc_data: got %h want 0", cdc_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    endtask

    task automatic test_single();
        int first_trig = -1;
        int trig_cycles = 0;
        int pulses = 0;
        int pulse_n = -1;
        int data_bad = 0;
        logic [N_REQ-1:0] ack_val = '0;
        apply_reset(1'b0);
        ack_auto = 1'b1;
        data_in[0 +: WIDTH] = 32'hDEADBEEF;
        req = 4'b0001;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (cdc_trigger) begin
                trig_cycles++;
                if (first_trig < 0) first_trig = n;
            end
            if (busy && cdc_data !== {2'd0, 32'hDEADBEEF}) data_bad++;
            if (req_ack !== 4'b0000) begin
                pulses++;
                pulse_n = n;
                ack_val = req_ack;
                req = 4'b0000;
            end
        end
        n_cmp++; if (first_trig != 2) begin n_err++; $display("FAIL single_trig_latency: got %0d want 2", first_trig); end
        n_cmp++; if (trig_cycles != 4) begin n_err++; $display("FAIL single_trig_cycles: got %0d want 4", trig_cycles); end
        n_cmp++; if (data_bad != 0) begin n_err++; $display("FAIL single_data_held: got %0d bad cycles want 0", data_bad); end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL single_ack_count: got %0d want 1", pulses); end
        n_cmp++; if (pulse_n != 10) begin n_err++; $display("FAIL single_ack_cycle: got %0d want 10", pulse_n); end
        n_cmp++; if (ack_val !== 4'b0001) begin n_err++; $display("FAIL single_ack_value: got %b want 0001", ack_val); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_after: got %b want 0", busy); end
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL single_grant_id: got %0d want 0", grant_id); end
    endtask

    task automatic test_round_robin();
        int exp_id [5] = '{0, 1, 2, 3, 0};
        logic [ID_W-1:0]       seen_id   [5];
        logic [ID_W+WIDTH-1:0] seen_data [5];
        logic [N_REQ-1:0]      seen_ack  [5];
        logic [ID_W+WIDTH-1:0] e_data;
        logic [N_REQ-1:0]      e_ack;
        logic trig_prev = 1'b0;
        int ntrig = 0;
        int nack = 0;
        for (int k = 0; k < 5; k++) begin
            seen_id[k] = 'x; seen_data[k] = 'x; seen_ack[k] = 'x;
        end
        apply_reset(1'b0);
        ack_auto = 1'b1;
        data_in = {32'h44, 32'h33, 32'h22, 32'h11};
        req = 4'b1111;
        for (int n = 0; n < 200 && nack < 5; n++) begin
            @(negedge clk);
            if (cdc_trigger && !trig_prev && ntrig < 5) begin
                seen_id[ntrig] = grant_id;
                seen_data[ntrig] = cdc_data;
                ntrig++;
            end
            trig_prev = cdc_trigger;
            if (req_ack !== 4'b0000) begin
                seen_ack[nack] = req_ack;
                nack++;
            end
        end
        n_cmp++; if (nack != 5) begin n_err++; $display("FAIL rr_ack_count: got %0d want 5", nack); end
        for (int k = 0; k < 5; k++) begin
            e_data = {ID_W'(exp_id[k]), WIDTH'(32'h11 * (exp_id[k] + 1))};
            e_ack  = 4'b0001 << exp_id[k];
            n_cmp++; if (seen_id[k] !== ID_W'(exp_id[k])) begin n_err++; $display("FAIL rr_grant_%0d: got %0d want %0d", k, seen_id[k], exp_id[k]); end
            n_cmp++; if (seen_data[k] !== e_data) begin n_err++; $display("FAIL rr_data_%0d: got %h want %h", k, seen_data[k], e_data); end
            n_cmp++; if (seen_ack[k] !== e_ack) begin n_err++; $display("FAIL rr_ack_%0d: got %b want %b", k, seen_ack[k], e_ack); end
        end
    endtask

    task automatic test_stale_ack();
        int stale_trig = 0;
        int stale_busy = 0;
        int first_trig = -1;
        int pulse_n = -1;
        logic [ID_W-1:0]  gid = '0;
        logic [N_REQ-1:0] ack_val = '0;
        apply_reset(1'b1);
        data_in[WIDTH +: WIDTH] = 32'h0BADF00D;
        req = 4'b0010;
        repeat (6) begin
            @(negedge clk);
            if (cdc_trigger) stale_trig++;
            if (busy) stale_busy++;
        end
        n_cmp++; if (stale_trig != 0) begin n_err++; $display("FAIL stale_no_trigger: got %0d cycles want 0", stale_trig); end
        n_cmp++; if (stale_busy != 0) begin n_err++; $display("FAIL stale_no_busy: got %0d cycles want 0", stale_busy); end
        ack_manual = 1'b0;
        ack_auto   = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (cdc_trigger && first_trig < 0) begin
                first_trig = n;
                gid = grant_id;
            end
            if (req_ack !== 4'b0000) begin
                pulse_n = n;
                ack_val = req_ack;
                req = 4'b0000;
            end
        end
        n_cmp++; if (first_trig != 2) begin n_err++; $display("FAIL stale_trig_latency: got %0d want 2", first_trig); end
        n_cmp++; if (gid !== 2'd1) begin n_err++; $display("FAIL stale_grant_id: got %0d want 1", gid); end
        n_cmp++; if (pulse_n != 10) begin n_err++; $display("FAIL stale_ack_cycle: got %0d want 10", pulse_n); end
        n_cmp++; if (ack_val !== 4'b0010) begin n_err++; $display("FAIL stale_ack_value: got %b want 0010", ack_val); end
    endtask

    task automatic test_drop_mid();
        int pulses = 0;
        int pulse_n = -1;
        int rises = 0;
        logic trig_prev = 1'b0;
        logic [N_REQ-1:0]      ack_val = '0;
        logic [ID_W+WIDTH-1:0] data_at_trig = '0;
        apply_reset(1'b0);
        ack_auto = 1'b1;
        data_in[2*WIDTH +: WIDTH] = 32'hCAFEF00D;
        req = 4'b0100;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (cdc_trigger && !trig_prev) begin
                rises++;
                data_at_trig = cdc_data;
            end
            trig_prev = cdc_trigger;
            if (cdc_trigger && req[2]) req = 4'b0000;
            if (req_ack !== 4'b0000) begin
                pulses++;
                pulse_n = n;
                ack_val = req_ack;
            end
        end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL drop_ack_count: got %0d want 1", pulses); end
        n_cmp++; if (ack_val !== 4'b0100) begin n_err++; $display("FAIL drop_ack_value: got %b want 0100", ack_val); end
        n_cmp++; if (pulse_n != 10) begin n_err++; $display("FAIL drop_ack_cycle: got %0d want 10", pulse_n); end
        n_cmp++; if (rises != 1) begin n_err++; $display("FAIL drop_grant_count: got %0d want 1", rises); end
        n_cmp++; if (data_at_trig !== {2'd2, 32'hCAFEF00D}) begin n_err++; $display("FAIL drop_cdc_data: got %h want %h", data_at_trig, {2'd2, 32'hCAFEF00D}); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_busy_after: got %b want 0", busy); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL drop_timeout_err: got %b want 0", timeout_err); end
    endtask

    task automatic test_reset_in_drain();
        logic found = 1'b0;
        apply_reset(1'b0);
        ack_auto = 1'b1;
        data_in[2*WIDTH +: WIDTH] = 32'hCAFEF00D;
        req = 4'b0100;
        for (int n = 1; n <= 30 && !found; n++) begin
            @(negedge clk);
            if (busy && !cdc_trigger && cdc_ack) found = 1'b1;
        end
        n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL drain_reached: got %b want 1", found); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (cdc_trigger !== 1'b0) begin n_err++; $display("FAIL drain_rst_trigger: got %b want 0", cdc_trigger); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drain_rst_busy: got %b want 0", busy); end
        n_cmp++; if (req_ack !== 4'b0000) begin n_err++; $display("FAIL drain_rst_req_ack: got %b want 0000", req_ack); end
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL drain_rst_grant_id: got %0d want 0", grant_id); end
        n_cmp++; if (cdc_data !== 34'h0) begin n_err++; $display("FAIL drain_rst_cdc_data: got %h want 0", cdc_data); end
        ack_auto   = 1'b0;
        ack_manual = 1'b0;
        req   = 4'b1111;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL drain_regrant_busy: got %b want 1", busy); end
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL drain_ptr_cleared: got grant %0d want 0", grant_id); end
        req = 4'b0000;
    endtask

`ifdef BUS_CDC_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int pulses = 0;
        logic busy_15 = 1'b0;
        logic busy_16 = 1'b1;
        logic err_16 = 1'b0;
        apply_reset(1'b0);
        data_in[0 +: WIDTH] = 32'h12345678;
        req = 4'b0001;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (req_ack !== 4'b0000) pulses++;
            if (n == 15) begin
                busy_15 = busy;
                req = 4'b0000;
            end
            if (n == 16) begin
                busy_16 = busy;
                err_16 = timeout_err;
            end
        end
        n_cmp++; if (busy_15 !== 1'b1) begin n_err++; $display("FAIL tmo_busy_15: got %b want 1", busy_15); end
        n_cmp++; if (busy_16 !== 1'b0) begin n_err++; $display("FAIL tmo_idle_16: got %b want 0", busy_16); end
        n_cmp++; if (err_16 !== 1'b1) begin n_err++; $display("FAIL tmo_err_set: got %b want 1", err_16); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_err_sticky: got %b want 1", timeout_err); end
        n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL tmo_no_ack: got %0d want 0", pulses); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stale_ack();
        test_drop_mid();
        test_reset_in_drain();
`ifdef BUS_CDC_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
